// File: rtl/l2_req_sequencer.sv
// l2_req_sequencer
//   L2-side consumer of the L1<->L2 arbiter. Pops one request at a time from the
//   arbiter's L1->L2 FIFO head, drives it onto the L2 bank req/ack port, and returns
//   read data (and optionally write acks) into the arbiter's L2->L1 input, tagged with
//   the source L1. Single clock domain (clk_L2), asynchronous active-high reset.
//
//   Optional feature macro: WRITE_ACK_EN
//     defined   -> writes also pass through RESPOND (resp_rw=1, resp_data=write data)
//     undefined -> writes retire silently on bank_ack
module l2_req_sequencer #(
    parameter int num_L1s        = 2,
    parameter int num_L1s_log    = 1,
    parameter int addr_width     = 32,
    parameter int data_width     = 256,
    parameter int cpu_id_width   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_L2,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    arb_valid,
    input  logic                    arb_rw,
    input  logic [addr_width-1:0]   arb_addr,
    input  logic [data_width-1:0]   arb_data,
    input  logic [cpu_id_width-1:0] arb_id,
    input  logic [num_L1s_log-1:0]  arb_which,
    output logic                    accept_L2,
    output logic                    bank_req,
    output logic                    bank_rw,
    output logic [addr_width-1:0]   bank_addr,
    output logic [data_width-1:0]   bank_wdata,
    input  logic                    bank_ack,
    input  logic [data_width-1:0]   bank_rdata,
    output logic                    resp_valid,
    output logic                    resp_rw,
    output logic [addr_width-1:0]   resp_addr,
    output logic [data_width-1:0]   resp_data,
    output logic [cpu_id_width-1:0] resp_id,
    output logic [num_L1s_log-1:0]  resp_which,
    input  logic [num_L1s-1:0]      resp_full,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [15:0]             req_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    typedef struct packed {
        logic                    rw;
        logic [addr_width-1:0]   addr;
        logic [data_width-1:0]   data;
        logic [cpu_id_width-1:0] id;
        logic [num_L1s_log-1:0]  which;
    } req_t;

    logic [1:0]            state_q;
    req_t                  req_q;
    logic [TW-1:0]         tmo_q;
    logic [data_width-1:0] resp_data_q;

    // Output decode: bank side and response side both present the one latched request.
    // accept_L2 is gated by reset so every output reads 0 the instant reset asserts.
    always_comb begin
        accept_L2  = (state_q == S_IDLE) && enable && arb_valid && !reset;
        bank_req   = (state_q == S_ISSUE);
        bank_rw    = req_q.rw;
        bank_addr  = req_q.addr;
        bank_wdata = req_q.data;
        resp_valid = (state_q == S_RESPOND) && !resp_full[req_q.which];
        resp_rw    = req_q.rw;
        resp_addr  = req_q.addr;
        resp_data  = resp_data_q;
        resp_id    = req_q.id;
        resp_which = req_q.which;
        busy       = (state_q != S_IDLE);
    end

    // Sequencer FSM: pop -> bank handshake (with timeout) -> optional response.
    always_ff @(posedge clk_L2 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            tmo_q       <= '0;
            resp_data_q <= '0;
            err_timeout <= 1'b0;
            req_count   <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_L2) begin
                        req_q   <= '{rw: arb_rw, addr: arb_addr, data: arb_data,
                                     id: arb_id, which: arb_which};
                        tmo_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bank_ack) begin
                        req_count <= req_count + 16'd1;
                        if (!req_q.rw) begin
                            resp_data_q <= bank_rdata;
                            state_q     <= S_RESPOND;
                        end else begin
`ifdef WRITE_ACK_EN
                            resp_data_q <= req_q.data;
                            state_q     <= S_RESPOND;
`else
                            state_q     <= S_IDLE;
`endif
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Bank never answered: abandon the request without a response.
                        err_timeout <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_RESPOND: begin
                    // Only the destination L1's full flag can stall the response.
                    if (resp_valid) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
